// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the single register file write port, plus RAW pending mask.
// Latency: grant in cycle N, registered write in cycle N+1, register file captures at the following edge.
// Backpressure: req_ready is one-hot (or zero); losers hold valid/id/data until granted; no grants during rst.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_id,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 write_en,
    output logic [4:0]           write_id,
    output logic [XLEN-1:0]      write_data,
    output logic [31:0]          pending_mask
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef struct packed {
        logic            en;
        logic [4:0]      id;
        logic [XLEN-1:0] data;
    } wb_t;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [4:0]      sel_id;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     pend;
    wb_t             wb_q;

    // Scan from rr_ptr, wrapping; only req_valid and rr_ptr feed the grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NREQ);
            end
        end
        if (rst) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_id   = req_id[5*i +: 5];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // x0 writes are consumed but never enabled; id/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            wb_q   <= '0;
        end else begin
            wb_q.en <= 1'b0;
            if (gnt_vld) begin
                rr_ptr    <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                wb_q.en   <= (sel_id != 5'd0);
                wb_q.id   <= sel_id;
                wb_q.data <= sel_data;
            end
        end
    end

    always_comb begin
        pend = '0;
        if (wb_q.en) begin
            pend[wb_q.id] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                pend[req_id[5*i +: 5]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    assign pending_mask = pend;
    assign write_en     = wb_q.en;
    assign write_id     = wb_q.id;
    assign write_data   = wb_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, directed multi-cycle sequences, random traffic vs model.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_id;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 write_en;
    logic [4:0]           write_id;
    logic [XLEN-1:0]      write_data;
    logic [31:0]          pending_mask;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id),
        .req_data(req_data), .req_ready(req_ready), .write_en(write_en),
        .write_id(write_id), .write_data(write_data), .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] rf [32];

    typedef struct {
        logic [NREQ-1:0]      v;
        logic [5*NREQ-1:0]    ids;
        logic [XLEN*NREQ-1:0] data;
        logic [NREQ-1:0]      exp_rdy;
        logic [31:0]          exp_mask;
        logic                 exp_we;
        logic [4:0]           exp_id;
        logic [XLEN-1:0]      exp_data;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] id, input logic [XLEN-1:0] d);
        req_valid[i] = v;
        req_id[5*i +: 5] = id;
        req_data[XLEN*i +: XLEN] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Register file as seen by the write port; call once per cycle at the sample point.
    task automatic capture();
        if (write_en) rf[write_id] = write_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_id = '0; req_data = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int g2, viol, prev0;
        int m_rr, g;
        logic m_we;
        logic [4:0] m_id;
        logic [XLEN-1:0] m_data;
        logic hv [NREQ];
        logic [4:0] hid [NREQ];
        logic [XLEN-1:0] hdat [NREQ];
        logic [XLEN-1:0] exp_rf [32];
        logic [NREQ-1:0] r;
        logic [31:0] emask;

        vt[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 32'h20, 1'b1, 5'd5, 32'hDEADBEEF};
        vt[1] = '{3'b110, {5'd4, 5'd3, 5'd0}, {32'h44, 32'h33, 32'h0}, 3'b010, 32'h18, 1'b1, 5'd3, 32'h33};
        vt[2] = '{3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 3'b100, 32'h200, 1'b1, 5'd9, 32'h99};
        vt[3] = '{3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF, 32'h0}, 3'b010, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF};
        vt[4] = '{3'b000, {5'd6, 5'd6, 5'd6}, {32'h5, 32'h5, 32'h5}, 3'b000, 32'h0, 1'b0, 5'd0, 32'h0};
        vt[5] = '{3'b111, {5'd8, 5'd7, 5'd7}, {32'h3, 32'h2, 32'h1}, 3'b001, 32'h180, 1'b1, 5'd7, 32'h1};

        // Reset state, with requests already presented during reset.
        rst = 1'b1;
        req_valid = 3'b111; req_id = {5'd3, 5'd2, 5'd1}; req_data = '1;
        step();
        @(negedge clk);
        check("rst_ready", req_ready, 3'b000);
        check("rst_we", write_en, 1'b0);
        check("rst_id", write_id, 5'd0);
        check("rst_data", write_data, 32'h0);
        check("rst_mask_inputs", pending_mask, 32'h0E);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            req_valid = vt[t].v; req_id = vt[t].ids; req_data = vt[t].data;
            @(negedge clk);
            check($sformatf("vec%0d_ready", t), req_ready, vt[t].exp_rdy);
            check($sformatf("vec%0d_mask", t), pending_mask, vt[t].exp_mask);
            step();
            req_valid = '0;
            @(negedge clk);
            check($sformatf("vec%0d_we", t), write_en, vt[t].exp_we);
            check($sformatf("vec%0d_id", t), write_id, vt[t].exp_id);
            check($sformatf("vec%0d_data", t), write_data, vt[t].exp_data);
            emask = (vt[t].exp_we && vt[t].exp_id != 0) ? (32'h1 << vt[t].exp_id) : 32'h0;
            check($sformatf("vec%0d_mask_out", t), pending_mask, emask);
            step();
            @(negedge clk);
            check($sformatf("vec%0d_we_idle", t), write_en, 1'b0);
        end

        // Three simultaneous requests drain in order 0,1,2.
        do_reset();
        set_req(0, 1, 5'd1, 32'h11); set_req(1, 1, 5'd2, 32'h22); set_req(2, 1, 5'd3, 32'h33);
        @(negedge clk);
        check("three_rdy0", req_ready, 3'b001);
        for (int c = 1; c <= 3; c++) begin
            step();
            set_req(c - 1, 0, 5'd0, 32'h0);
            @(negedge clk);
            check($sformatf("three_rdy%0d", c), req_ready, (c < 3) ? (3'b001 << c) : 3'b000);
            check($sformatf("three_we%0d", c), write_en, 1'b1);
            check($sformatf("three_id%0d", c), write_id, 5'(c));
            check($sformatf("three_data%0d", c), write_data, 32'h11 * c);
        end

        // Fairness: requester 0 always valid, requester 2 arrives in cycle 4.
        do_reset();
        g2 = -1; viol = 0; prev0 = 0;
        set_req(0, 1, 5'd12, 32'h100);
        for (int c = 0; c < 12; c++) begin
            if (c == 4) set_req(2, 1, 5'd10, 32'hCAFE);
            @(negedge clk);
            r = req_ready;
            if (req_valid[2] && prev0 != 0 && r[0]) viol++;
            if (r[2] && g2 < 0) g2 = c;
            prev0 = r[0];
            step();
            if (r[2]) set_req(2, 0, 5'd0, 32'h0);
            if (r[0]) set_req(0, 1, 5'd12, 32'h100 + c + 1);
        end
        check("fair_grant2_cycle", g2, 4);
        check("fair_no_double", viol, 0);

        // Same destination: last grant wins.
        do_reset();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        set_req(0, 1, 5'd7, 32'hA); set_req(1, 1, 5'd7, 32'hB);
        @(negedge clk);
        check("same_rdy0", req_ready, 3'b001);
        check("same_mask", pending_mask, 32'h80);
        step(); set_req(0, 0, 5'd0, 32'h0);
        @(negedge clk);
        capture();
        check("same_c1_data", write_data, 32'hA);
        check("same_c1_rdy", req_ready, 3'b010);
        step(); set_req(1, 0, 5'd0, 32'h0);
        @(negedge clk);
        capture();
        check("same_c2_data", write_data, 32'hB);
        check("same_c2_we", write_en, 1'b1);
        step();
        @(negedge clk);
        capture();
        check("same_rf_x7", rf[7], 32'hB);

        // Reset mid-stream after a requester-2 handshake.
        do_reset();
        set_req(2, 1, 5'd6, 32'h66);
        @(negedge clk);
        check("rm_rdy2", req_ready, 3'b100);
        step();
        rst = 1'b1;
        set_req(2, 0, 5'd0, 32'h0); set_req(0, 1, 5'd4, 32'h40); set_req(1, 1, 5'd5, 32'h50);
        @(negedge clk);
        check("rm_rdy_in_rst", req_ready, 3'b000);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rm_we_dropped", write_en, 1'b0);
        check("rm_rdy_after", req_ready, 3'b001);
        step();
        set_req(0, 1, 5'd4, 32'h41);
        rst = 1'b1;
        @(negedge clk);
        check("rm2_rdy_in_rst", req_ready, 3'b000);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rm2_ptr_restart", req_ready, 3'b001);
        check("rm2_we_dropped", write_en, 1'b0);

        // Random traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 32; i++) begin rf[i] = '0; exp_rf[i] = '0; end
        m_rr = 0; m_we = 1'b0; m_id = '0; m_data = '0;
        for (int i = 0; i < NREQ; i++) begin hv[i] = 1'b0; hid[i] = '0; hdat[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hv[i] && $urandom_range(0, 99) < 45) begin
                    hv[i] = 1'b1;
                    hid[i] = 5'($urandom_range(0, 9));
                    hdat[i] = $urandom;
                end
                set_req(i, hv[i], hid[i], hdat[i]);
            end
            @(negedge clk);
            capture();
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && hv[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
            emask = '0;
            if (m_we) emask[m_id] = 1'b1;
            for (int i = 0; i < NREQ; i++) if (hv[i]) emask[hid[i]] = 1'b1;
            emask[0] = 1'b0;
            check("rnd_ready", req_ready, (g >= 0) ? (3'b001 << g) : 3'b000);
            check("rnd_mask", pending_mask, emask);
            check("rnd_we", write_en, m_we);
            if (m_we) begin
                check("rnd_id", write_id, m_id);
                check("rnd_data", write_data, m_data);
            end
            if (g >= 0) begin
                m_we = (hid[g] != 0); m_id = hid[g]; m_data = hdat[g];
                if (m_we) exp_rf[m_id] = m_data;
                m_rr = (g + 1) % NREQ;
                hv[g] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            capture();
            step();
        end
        for (int i = 1; i < 32; i++) check($sformatf("rnd_rf_x%0d", i), rf[i], exp_rf[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
